// File: rtl/packetizer.sv
// packetizer: buffers a valid/ready 16-bit word stream and emits one 48-bit flit per word.
// Define PACKETIZER_TIMEOUT_EN to close idle open packets with a tail-only flit.
module packetizer #(
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned MAX_FLITS      = 16,
   parameter int unsigned TIMEOUT_CYCLES = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] data_in,
   input  logic        data_last,
   input  logic        data_valid,
   output logic        data_ready,
   input  logic [7:0]  dest_id,
   output logic [47:0] flit_out,
   output logic        flit_valid,
   input  logic        flit_ready,
   output logic        busy,
   output logic [15:0] pkt_count
);
   localparam int unsigned AW       = $clog2(FIFO_DEPTH);
   localparam logic [7:0]  LAST_SEQ = 8'(MAX_FLITS - 1);

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || MAX_FLITS < 2 ||
       MAX_FLITS > 256 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
      $error("packetizer: illegal parameter value");
   end

   typedef enum logic {StIdle, StActive} state_e;

   logic [16:0] mem_q [FIFO_DEPTH];
   logic [AW:0] wr_ptr_q, rd_ptr_q;
   logic        ready_en_q;
   logic        full, empty, push, pop, can_load;
   logic [16:0] head;

   state_e      state_q, state_d;
   logic [7:0]  hdr_q, hdr_d;
   logic [7:0]  seq_q, seq_d;
   logic [47:0] flit_q, flit_d;
   logic        flit_valid_q, flit_valid_d;
   logic [15:0] pkt_q, pkt_d;
   logic [7:0]  cur_dest;
   logic        tail;
   logic        timeout_fire;

   // Extra pointer MSB distinguishes full from empty.
   assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty      = (wr_ptr_q == rd_ptr_q);
   assign data_ready = ready_en_q && !full;
   assign push       = data_valid && data_ready;
   assign can_load   = !flit_valid_q || flit_ready;
   assign pop        = !empty && can_load;
   assign head       = mem_q[rd_ptr_q[AW-1:0]];

   assign cur_dest   = (state_q == StIdle) ? dest_id : hdr_q;
   assign tail       = head[16] || (seq_q == LAST_SEQ);

   assign flit_out   = flit_q;
   assign flit_valid = flit_valid_q;
   assign busy       = (state_q == StActive);
   assign pkt_count  = pkt_q;

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= {data_last, data_in};
   end

   // seq_q always holds the sequence index of the next flit of the packet.
   always_comb begin
      state_d      = state_q;
      hdr_d        = hdr_q;
      seq_d        = seq_q;
      flit_d       = flit_q;
      flit_valid_d = flit_valid_q;
      pkt_d        = pkt_q;
      if (flit_valid_q && flit_ready) flit_valid_d = 1'b0;
      if (pop) begin
         flit_d       = {cur_dest, seq_q, head[15:0], tail ? 16'hFFFF : 16'h0000};
         flit_valid_d = 1'b1;
         if (state_q == StIdle) hdr_d = dest_id;
         if (tail) begin
            state_d = StIdle;
            seq_d   = 8'd0;
            pkt_d   = pkt_q + 16'd1;
         end else begin
            state_d = StActive;
            seq_d   = seq_q + 8'd1;
         end
      end else if (timeout_fire) begin
         flit_d       = {hdr_q, seq_q, 16'h0000, 16'hFFFF};
         flit_valid_d = 1'b1;
         state_d      = StIdle;
         seq_d        = 8'd0;
         pkt_d        = pkt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         ready_en_q   <= 1'b0;
         state_q      <= StIdle;
         hdr_q        <= 8'd0;
         seq_q        <= 8'd0;
         flit_q       <= 48'h0;
         flit_valid_q <= 1'b0;
         pkt_q        <= 16'd0;
      end else begin
         ready_en_q   <= 1'b1;
         if (push) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
         if (pop)  rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
         state_q      <= state_d;
         hdr_q        <= hdr_d;
         seq_q        <= seq_d;
         flit_q       <= flit_d;
         flit_valid_q <= flit_valid_d;
         pkt_q        <= pkt_d;
      end
   end

`ifdef PACKETIZER_TIMEOUT_EN
   logic [15:0] to_cnt_q, to_cnt_d;
   logic        to_reached;

   assign to_reached = (to_cnt_q >= 16'(TIMEOUT_CYCLES));

   // A word arriving in the firing cycle wins over the timeout tail.
   always_comb begin
      to_cnt_d     = to_cnt_q;
      timeout_fire = (state_q == StActive) && empty && !push && to_reached && can_load;
      if (state_q != StActive || pop || push || timeout_fire) begin
         to_cnt_d = 16'd0;
      end else if (empty && !to_reached) begin
         to_cnt_d = to_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) to_cnt_q <= 16'd0;
      else       to_cnt_q <= to_cnt_d;
   end
`else
   assign timeout_fire = 1'b0;
`endif

endmodule

// File: tb/tb_packetizer.sv
// tb_packetizer: directed literal-flit tests plus randomized batches checked against
// a packet-rule reference model; timeout test runs when PACKETIZER_TIMEOUT_EN is defined.
module tb_packetizer;
   localparam int unsigned FIFO_DEPTH     = 4;
   localparam int unsigned MAX_FLITS      = 4;
   localparam int unsigned TIMEOUT_CYCLES = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] data_in = 16'h0;
   logic        data_last = 1'b0;
   logic        data_valid = 1'b0;
   logic        data_ready;
   logic [7:0]  dest_id = 8'h0;
   logic [47:0] flit_out;
   logic        flit_valid;
   logic        flit_ready = 1'b0;
   logic        busy;
   logic [15:0] pkt_count;

   packetizer #(
      .FIFO_DEPTH     (FIFO_DEPTH),
      .MAX_FLITS      (MAX_FLITS),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .data_in    (data_in),
      .data_last  (data_last),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .dest_id    (dest_id),
      .flit_out   (flit_out),
      .flit_valid (flit_valid),
      .flit_ready (flit_ready),
      .busy       (busy),
      .pkt_count  (pkt_count)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          accepts = 0;
   int          last_acc_cyc = 0;
   int          pkt_exp = 0;
   int          m_seq = 0;
   logic [7:0]  m_hdr = 8'h0;
   bit          use_model = 1'b0;
   bit          pushed_now = 1'b0;
   bit          hold_chk = 1'b0;
   logic [47:0] hold_flit = 48'h0;
   logic [47:0] exp_q[$];
   logic [16:0] tx_q[$];

   task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: each word becomes one flit; a packet closes on last or at MAX_FLITS flits.
   function automatic void model_push(input logic [15:0] d, input logic l);
      bit t;
      t = l || (m_seq == int'(MAX_FLITS) - 1);
      if (m_seq == 0) m_hdr = dest_id;
      exp_q.push_back({m_hdr, 8'(m_seq), d, t ? 16'hFFFF : 16'h0000});
      if (t) begin
         m_seq = 0;
         pkt_exp++;
      end else begin
         m_seq++;
      end
   endfunction

   // One clock: sample at the falling edge, then return 1 time unit after the rising edge.
   task automatic step();
      logic [47:0] e;
      @(negedge clk);
      cyc++;
      if (hold_chk) begin
         chk("hold_valid", 48'(flit_valid), 48'd1);
         chk("hold_data", flit_out, hold_flit);
      end
      pushed_now = data_valid && data_ready;
      if (pushed_now && use_model) model_push(data_in, data_last);
      if (flit_valid && flit_ready) begin
         accepts++;
         last_acc_cyc = cyc;
         e = (exp_q.size() != 0) ? exp_q.pop_front() : 48'hDEAD_BEEF_DEAD;
         chk("flit", flit_out, e);
      end
      hold_chk  = flit_valid && !flit_ready;
      hold_flit = flit_out;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input bit rand_valid, input bit rand_ready);
      int n = 0;
      int idle = 0;
      while (tx_q.size() != 0 && n < 2000) begin
         {data_last, data_in} = tx_q[0];
         data_valid = !rand_valid || idle >= 3 || $urandom_range(0, 3) != 0;
         idle = data_valid ? 0 : idle + 1;
         if (rand_ready) flit_ready = ($urandom_range(0, 9) < 6);
         step();
         if (pushed_now) void'(tx_q.pop_front());
         n++;
      end
      data_valid = 1'b0;
      chk("send_bound", 48'(tx_q.size()), 48'd0);
   endtask

   task automatic drain();
      int n = 0;
      data_valid = 1'b0;
      flit_ready = 1'b1;
      while ((exp_q.size() != 0 || flit_valid) && n < 300) begin
         step();
         n++;
      end
      chk("drain_bound", 48'(n < 300), 48'd1);
   endtask

   task automatic wait_accepts(input int target, input int bound);
      int n = 0;
      while (accepts < target && n < bound) begin
         step();
         n++;
      end
      chk("accept_bound", 48'(accepts >= target), 48'd1);
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      data_valid = 1'b0;
      flit_ready = 1'b0;
      #1;
      chk("rst_flit_valid", 48'(flit_valid), 48'd0);
      chk("rst_flit_out", flit_out, 48'h0);
      chk("rst_pkt_count", 48'(pkt_count), 48'd0);
      chk("rst_data_ready", 48'(data_ready), 48'd0);
      chk("rst_busy", 48'(busy), 48'd0);
      exp_q.delete();
      hold_chk = 1'b0;
      m_seq = 0;
      pkt_exp = 0;
      step();
      step();
      reset = 1'b0;
      step();
      chk("ready_after_reset", 48'(data_ready), 48'd1);
   endtask

   initial begin
      int a0;
      int t1;
      #500_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0;
      int t1;
      int nw;
      #2;
      apply_reset();

      // Three-word packet.
      dest_id = 8'h05;
      flit_ready = 1'b1;
      exp_q.push_back(48'h05_00_1111_0000);
      exp_q.push_back(48'h05_01_2222_0000);
      exp_q.push_back(48'h05_02_3333_FFFF);
      tx_q.push_back({1'b0, 16'h1111});
      tx_q.push_back({1'b0, 16'h2222});
      tx_q.push_back({1'b1, 16'h3333});
      send(1'b0, 1'b0);
      drain();
      pkt_exp = 1;
      chk("pkt_3word", 48'(pkt_count), 48'(pkt_exp));

      // Forced tail at MAX_FLITS, then a 2-flit packet.
      dest_id = 8'h09;
      exp_q.push_back(48'h09_00_C001_0000);
      exp_q.push_back(48'h09_01_C002_0000);
      exp_q.push_back(48'h09_02_C003_0000);
      exp_q.push_back(48'h09_03_C004_FFFF);
      exp_q.push_back(48'h09_00_C005_0000);
      exp_q.push_back(48'h09_01_C006_FFFF);
      for (int i = 1; i <= 6; i++) tx_q.push_back({i == 6, 16'hC000 + 16'(i)});
      send(1'b0, 1'b0);
      drain();
      pkt_exp = 3;
      chk("pkt_forced", 48'(pkt_count), 48'(pkt_exp));

      // Backpressure: 4 FIFO entries plus one held flit, then release.
      dest_id = 8'h07;
      exp_q.push_back(48'h07_00_B001_0000);
      exp_q.push_back(48'h07_01_B002_0000);
      exp_q.push_back(48'h07_02_B003_0000);
      exp_q.push_back(48'h07_03_B004_FFFF);
      exp_q.push_back(48'h07_00_B005_0000);
      exp_q.push_back(48'h07_01_B006_FFFF);
      for (int i = 1; i <= 6; i++) tx_q.push_back({i == 6, 16'hB000 + 16'(i)});
      flit_ready = 1'b0;
      for (int c = 0; c < 10; c++) begin
         {data_last, data_in} = tx_q[0];
         data_valid = 1'b1;
         step();
         if (pushed_now) void'(tx_q.pop_front());
      end
      chk("bp_accepted", 48'(6 - tx_q.size()), 48'd5);
      chk("bp_ready_low", 48'(data_ready), 48'd0);
      chk("bp_flit_valid", 48'(flit_valid), 48'd1);
      chk("bp_flit_out", flit_out, 48'h07_00_B001_0000);
      flit_ready = 1'b1;
      send(1'b0, 1'b0);
      drain();
      pkt_exp = 5;
      chk("pkt_bp", 48'(pkt_count), 48'(pkt_exp));

      // Open packet; dest change mid-packet is ignored.
      dest_id = 8'h0C;
      exp_q.push_back(48'h0C_00_D001_0000);
      tx_q.push_back({1'b0, 16'hD001});
      a0 = accepts;
      send(1'b0, 1'b0);
      wait_accepts(a0 + 1, 20);
      chk("busy_open", 48'(busy), 48'd1);
`ifndef PACKETIZER_TIMEOUT_EN
      repeat (30) step();
      chk("open_stays", 48'(busy), 48'd1);
      chk("open_no_flit", 48'(flit_valid), 48'd0);
`endif
      dest_id = 8'h66;
      exp_q.push_back(48'h0C_01_D002_FFFF);
      exp_q.push_back(48'h66_00_D003_FFFF);
      tx_q.push_back({1'b1, 16'hD002});
      tx_q.push_back({1'b1, 16'hD003});
      send(1'b0, 1'b0);
      drain();
      pkt_exp = 7;
      chk("pkt_dest", 48'(pkt_count), 48'(pkt_exp));
      chk("busy_idle", 48'(busy), 48'd0);

      // Reset mid-packet after two flits.
      dest_id = 8'h0A;
      exp_q.push_back(48'h0A_00_E001_0000);
      exp_q.push_back(48'h0A_01_E002_0000);
      exp_q.push_back(48'h0A_02_E003_0000);
      for (int i = 1; i <= 3; i++) tx_q.push_back({1'b0, 16'hE000 + 16'(i)});
      a0 = accepts;
      send(1'b0, 1'b0);
      wait_accepts(a0 + 2, 20);
      apply_reset();
      dest_id = 8'h0B;
      flit_ready = 1'b1;
      exp_q.push_back(48'h0B_00_E004_FFFF);
      tx_q.push_back({1'b1, 16'hE004});
      send(1'b0, 1'b0);
      drain();
      pkt_exp = 1;
      chk("pkt_after_rst", 48'(pkt_count), 48'(pkt_exp));

`ifdef PACKETIZER_TIMEOUT_EN
      // Idle timeout closes the open packet with a tail-only flit.
      dest_id = 8'h0D;
      exp_q.push_back(48'h0D_00_F001_0000);
      exp_q.push_back(48'h0D_01_0000_FFFF);
      tx_q.push_back({1'b0, 16'hF001});
      a0 = accepts;
      send(1'b0, 1'b0);
      wait_accepts(a0 + 1, 20);
      t1 = last_acc_cyc;
      wait_accepts(a0 + 2, 40);
      chk("to_gap_min", 48'(last_acc_cyc - t1 >= int'(TIMEOUT_CYCLES)), 48'd1);
      chk("to_gap_max", 48'(last_acc_cyc - t1 <= int'(TIMEOUT_CYCLES) + 2), 48'd1);
      drain();
      pkt_exp = 2;
      chk("pkt_timeout", 48'(pkt_count), 48'(pkt_exp));
      chk("to_busy", 48'(busy), 48'd0);
`endif

      // Randomized batches against the reference model.
      use_model = 1'b1;
      for (int b = 0; b < 6; b++) begin
         dest_id = 8'($urandom);
         nw = $urandom_range(8, 24);
         for (int i = 0; i < nw; i++) begin
            tx_q.push_back({(i == nw - 1) || ($urandom_range(0, 4) == 0), 16'($urandom)});
         end
         send(1'b1, 1'b1);
         drain();
         chk("pkt_random", 48'(pkt_count), 48'(pkt_exp));
         chk("busy_random", 48'(busy), 48'd0);
      end
      use_model = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/packetizer.md
Name: packetizer

Overview:
- Upstream neighbour of the de-packetizer stage.
- Accepts a 16-bit word stream with valid/ready handshake and a per-word last flag, and buffers words in a small FIFO.
- Emits one 48-bit flit per word. Flit format: [47:40] dest_id, [39:32] flit sequence index within the packet, [31:16] payload, [15:0] tail marker.
- Tail marker is 16'hFFFF on the packet's final flit and 16'h0000 otherwise, so the downstream stage recovers data from [31:16] and packet_end from [15:0].

Parameters:
- FIFO_DEPTH, 4, input FIFO entries; power of two, minimum 2.
- MAX_FLITS, 16, maximum flits per packet (2..256); reaching it forces a tail.
- TIMEOUT_CYCLES, 32, idle-gap limit used only with the optional feature (1..65535).

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- data_in  input  16  payload word
- data_last  input  1  marks the final word of a packet
- data_valid  input  1  data_in/data_last valid
- data_ready  output  1  FIFO can accept; high when FIFO not full
- dest_id  input  8  destination; sampled with the first word of each packet
- flit_out  output  48  formatted flit
- flit_valid  output  1  flit_out valid
- flit_ready  input  1  downstream accepts; tie high when downstream has no backpressure
- busy  output  1  FSM in ACTIVE
- pkt_count  output  16  count of completed packets; wraps at 16'hFFFF->0

Behaviour:
- Reset values:
  - All outputs 0 (flit_out 48'h0, flit_valid 0, busy 0, pkt_count 0); data_ready 0 while reset asserted.
  - FIFO emptied, FSM returns to IDLE, seq 0, timeout counter 0.
  - Reset mid-packet discards buffered words and any held flit; no tail is emitted.
- Input FIFO:
  - Entry is {data_last, data_in}; write on data_valid && data_ready.
  - data_ready = !full, registered-state based.
  - Simultaneous write and read when full is not permitted, since ready is low.
  - Simultaneous write and read when not full is legal; occupancy is unchanged.
- Output register:
  - Load condition: FIFO non-empty && (!flit_valid || flit_ready). The load pops one FIFO entry.
  - flit_valid and flit_out hold stable while flit_valid && !flit_ready.
  - Throughput: 1 flit/cycle with flit_ready high.
  - Latency: word accepted at edge N appears on flit_out after edge N+1.
- FSM:
  - IDLE: on a load, latch dest_id into hdr_dest. The flit uses the current dest_id, seq 0. Go to ACTIVE, unless the word is a tail, in which case stay in IDLE.
  - ACTIVE: each load uses hdr_dest and seq+1. dest_id changes mid-packet are ignored.
- Tail condition: popped data_last==1 OR seq==MAX_FLITS-1.
  - On tail: [15:0]=16'hFFFF, seq resets to 0, FSM goes to IDLE, pkt_count increments at the load edge.
  - A forced tail at MAX_FLITS starts a new packet with the next word; that word's last flag is honoured normally.
- Single-word packet (data_last on first word): one flit, seq 0, tail FFFF.
- pkt_count increments once per tail load, including timeout tails.

Optional Feature:
- Macro: PACKETIZER_TIMEOUT_EN.
- Enabled:
  - In ACTIVE with FIFO empty, a 16-bit counter increments each cycle; it clears on any load or on leaving ACTIVE.
  - On reaching TIMEOUT_CYCLES, when the output register can load, the block emits a tail-only flit: hdr_dest, seq+1, payload 16'h0000, tail 16'hFFFF. FSM goes to IDLE and pkt_count increments.
  - If a word arrives in the same cycle the timeout fires, the FIFO word wins and the counter clears.
- Disabled: no counter logic; a packet stays open indefinitely until data_last or MAX_FLITS.

Test Plan:
- Reset check: reset 1 -> flit_valid 0, flit_out 0, pkt_count 0, data_ready 0. Release, then data_ready 1 next cycle.
- 3-word packet: words 16'h1111, 16'h2222, 16'h3333 (last), dest 8'h05, flit_ready 1 -> flits 48'h05_00_1111_0000, 48'h05_01_2222_0000, 48'h05_02_3333_FFFF; pkt_count 1.
- Backpressure: flit_ready 0 for 6 cycles during 6-word stream, FIFO_DEPTH 4 -> flit_out stable, data_ready low after 5 words accepted (4 FIFO + 1 held), no loss or duplication after release.
- Forced tail: MAX_FLITS 4, 6 words with last on word 6 -> flit seq 3 carries FFFF, next packet seq 0,1 with FFFF on seq 1; pkt_count 2.
- Reset mid-packet after 2 flits -> outputs cleared; a following single-word packet emits seq 0 with FFFF.
- PACKETIZER_TIMEOUT_EN, TIMEOUT_CYCLES 8: send 1 non-last word, idle -> after 8 empty cycles the flit with seq 1, payload 0000, tail FFFF is emitted; pkt_count 1.
